motor_req_enc: RTL

- Request-side partner of the motor one-hot demultiplexer.
- Takes four per-motor request lines and arbitrates among them round-robin.
- Produces the 3-bit motor code plus enable that drive the demux.
- Times each motor run and enforces a dead-time gap between runs, so only one motor is ever commanded.

---
 rtl/motor_req_enc_if.sv | 38 +++
 rtl/motor_req_enc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/motor_req_enc_if.sv
// Request/command bundle between a requester and the motor request encoder.
//   i_req    : level request per motor, bit k requests motor k
//   i_abort  : terminate the current run and flush pending requests
//   o_motor  : motor code to the demux (3'b001..3'b100 = motor 0..3, 3'b000 idle)
//   o_enable : high while a motor run is active
//   o_busy   : high while running or in the dead-time gap
//   o_done   : one-cycle pulse when a run completes normally
interface motor_req_enc_if;
    localparam int unsigned N_MOTOR = 4;
    localparam int unsigned CODE_W  = 3;

    logic [N_MOTOR-1:0] i_req;
    logic               i_abort;
    logic [CODE_W-1:0]  o_motor;
    logic               o_enable;
    logic               o_busy;
    logic               o_done;

    // Requester side
    modport master (
        output i_req,
        output i_abort,
        input  o_motor,
        input  o_enable,
        input  o_busy,
        input  o_done
    );

    // Encoder side
    modport slave (
        input  i_req,
        input  i_abort,
        output o_motor,
        output o_enable,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/motor_req_enc.sv
// Round-robin motor request encoder with run timing and dead-time gap.
// Latches per-motor requests, grants one motor at a time, holds the motor
// code and enable for RUN_CYCLES, then idles GAP_CYCLES before the next grant.
//   i_Clk : system clock, rising edge
//   i_Rst : asynchronous active-low reset
//   bus   : motor_req_enc_if.slave (i_req, i_abort in; o_motor, o_enable,
//           o_busy, o_done out, all outputs registered)
module motor_req_enc #(
    parameter int unsigned RUN_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    motor_req_enc_if.slave bus
);

    localparam int unsigned N_MOTOR = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CODE_W  = 3;

    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q,   state_nxt;
    logic [CNT_W-1:0]   cnt_q,     cnt_nxt;
    logic [N_MOTOR-1:0] pending_q, pending_nxt;
    logic [IDX_W-1:0]   last_q,    last_nxt;

    logic [CODE_W-1:0]  motor_q,   motor_nxt;
    logic               enable_q,  enable_nxt;
    logic               busy_q,    busy_nxt;
    logic               done_q,    done_nxt;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic               grant;

    // Round-robin search starting just after the last grant, ending on it
    always_comb begin
        win_valid = 1'b0;
        win_idx   = last_q;
        scan_idx  = last_q;
        for (int k = 1; k <= N_MOTOR; k++) begin
            scan_idx = last_q + IDX_W'(k);
            if (!win_valid && pending_q[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // A grant only happens from IDLE, and abort always vetoes it
    assign grant = (state_q == ST_IDLE) && win_valid && !bus.i_abort;

    // State register plus registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            last_q    <= IDX_W'(N_MOTOR - 1);
            motor_q   <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            pending_q <= pending_nxt;
            last_q    <= last_nxt;
            motor_q   <= motor_nxt;
            enable_q  <= enable_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

    // Next-state: sequencing, run/gap counter, pending queue, grant pointer
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        pending_nxt = pending_q | bus.i_req;
        last_nxt    = last_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = RUN_LOAD;
                end
            end
            ST_RUN: begin
                if (bus.i_abort || (cnt_q == '0)) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Granted bit is consumed unless the same motor is re-requesting now
        if (grant) begin
            pending_nxt[win_idx] = bus.i_req[win_idx];
            last_nxt             = win_idx;
        end

        if (bus.i_abort) begin
            pending_nxt = '0;
        end
    end

    // Output decode of the upcoming state; done only on a normal run end
    always_comb begin
        motor_nxt  = '0;
        enable_nxt = 1'b0;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;

        if (state_nxt == ST_RUN) begin
            motor_nxt  = CODE_W'(last_nxt) + CODE_W'(1);
            enable_nxt = 1'b1;
        end
        if (state_nxt != ST_IDLE) begin
            busy_nxt = 1'b1;
        end
        if ((state_q == ST_RUN) && (state_nxt == ST_GAP) && !bus.i_abort) begin
            done_nxt = 1'b1;
        end
    end

    assign bus.o_motor  = motor_q;
    assign bus.o_enable = enable_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;

endmodule
